// File: rtl/axppa_pkg.sv
// +----------------------------------------------------------------------------+
// | axppa_pkg : shared state encoding, default widths and ED helper            |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

package axppa_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CNT_W = 32;
    localparam int DEF_ACC_W = 48;
    localparam int ED_MAX_W  = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Operands are zero-extended by the caller; result is truncated back to the sum width.
    function automatic logic [ED_MAX_W-1:0] ed_abs(input logic [ED_MAX_W-1:0] exact,
                                                  input logic [ED_MAX_W-1:0] approx);
        ed_abs = (exact >= approx) ? (exact - approx) : (approx - exact);
    endfunction

endpackage

`default_nettype wire

// File: rtl/axppa_ed_stage.sv
// +----------------------------------------------------------------------------+
// | axppa_ed_stage : S1 exact add and S2 absolute error distance               |
// | Revision       : 1.0                                                       |
// +----------------------------------------------------------------------------+
`default_nettype none

module axppa_ed_stage
    import axppa_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             accept,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [WIDTH:0]   approx_sum,
    output logic             ed_valid,
    output logic [WIDTH:0]   ed,
    output logic             err,
    output logic             busy
);

    localparam int ED_W = WIDTH + 1;

    logic            r_s1_valid;
    logic [ED_W-1:0] r_s1_exact;
    logic [ED_W-1:0] r_s1_approx;
    logic            r_s2_valid;
    logic [ED_W-1:0] r_s2_ed;
    logic            r_s2_err;
    logic [ED_W-1:0] w_ed;

    assign w_ed = ED_W'(ed_abs(ED_MAX_W'(r_s1_exact), ED_MAX_W'(r_s1_approx)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_exact  <= '0;
            r_s1_approx <= '0;
            r_s2_valid  <= 1'b0;
            r_s2_ed     <= '0;
            r_s2_err    <= 1'b0;
        end else begin
            r_s1_valid <= accept;
            if (accept) begin
                r_s1_exact  <= {1'b0, op_a} + {1'b0, op_b};
                r_s1_approx <= approx_sum;
            end
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_ed  <= w_ed;
                r_s2_err <= |w_ed;
            end
        end
    end

    assign ed_valid = r_s2_valid;
    assign ed       = r_s2_ed;
    assign err      = r_s2_err;
    assign busy     = r_s1_valid | r_s2_valid;

endmodule

`default_nettype wire

// File: rtl/axppa_error_monitor.sv
// +----------------------------------------------------------------------------+
// | axppa_error_monitor : run control and error metric accumulation            |
// | Revision            : 1.0                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module axppa_error_monitor
    import axppa_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [WIDTH:0]   approx_sum,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] err_count,
    output logic [WIDTH:0]   max_ed,
    output logic [ACC_W-1:0] sum_ed
);

    localparam int ED_W  = WIDTH + 1;
    localparam int SAT_W = ((ACC_W > ED_W) ? ACC_W : ED_W) + 1;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_num;
    logic [CNT_W-1:0] r_sample_cnt;
    logic [CNT_W-1:0] r_err_count;
    logic [ED_W-1:0]  r_max_ed;
    logic [ACC_W-1:0] r_sum_ed;
    logic             r_s3_valid;
    logic [ED_W-1:0]  r_s3_ed;
    logic             r_s3_err;
    logic             w_s2_valid;
    logic [ED_W-1:0]  w_s2_ed;
    logic             w_s2_err;
    logic             w_stage_busy;
    logic             w_accept;
    logic             w_last;
    logic             w_start_run;
    logic [SAT_W-1:0] w_sum_wide;
    logic [ACC_W-1:0] w_sum_next;

    assign w_accept    = in_valid && (r_state == RUN);
    assign w_last      = w_accept && ((r_sample_cnt + CNT_W'(1)) == r_num);
    assign w_start_run = start && ((r_state == IDLE) || (r_state == DONE));

    axppa_ed_stage #(
        .WIDTH (WIDTH)
    ) u_ed_stage (
        .clk        (clk),
        .rst        (rst),
        .accept     (w_accept),
        .op_a       (op_a),
        .op_b       (op_b),
        .approx_sum (approx_sum),
        .ed_valid   (w_s2_valid),
        .ed         (w_s2_ed),
        .err        (w_s2_err),
        .busy       (w_stage_busy)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // Start is only honoured from IDLE/DONE, so a start coinciding with the final accept is dropped.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, DONE: if (start) w_state_next = (num_samples == '0) ? DONE : RUN;
            RUN:        if (w_last) w_state_next = DRAIN;
            DRAIN:      if (!w_stage_busy && !r_s3_valid) w_state_next = DONE;
            default:    w_state_next = IDLE;
        endcase
    end

    // Widened add so the saturation test also covers ACC_W narrower than the ED.
    assign w_sum_wide = SAT_W'(r_sum_ed) + SAT_W'(r_s3_ed);
    assign w_sum_next = (|w_sum_wide[SAT_W-1:ACC_W]) ? {ACC_W{1'b1}} : w_sum_wide[ACC_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_num        <= '0;
            r_sample_cnt <= '0;
            r_err_count  <= '0;
            r_max_ed     <= '0;
            r_sum_ed     <= '0;
            r_s3_valid   <= 1'b0;
            r_s3_ed      <= '0;
            r_s3_err     <= 1'b0;
        end else begin
            r_s3_valid <= w_s2_valid;
            if (w_s2_valid) begin
                r_s3_ed  <= w_s2_ed;
                r_s3_err <= w_s2_err;
            end
            if (w_start_run) begin
                r_num        <= num_samples;
                r_sample_cnt <= '0;
                r_err_count  <= '0;
                r_max_ed     <= '0;
                r_sum_ed     <= '0;
            end else begin
                if (w_accept) r_sample_cnt <= r_sample_cnt + CNT_W'(1);
                if (r_s3_valid) begin
                    r_err_count <= r_err_count + CNT_W'(r_s3_err);
                    if (r_s3_ed > r_max_ed) r_max_ed <= r_s3_ed;
                    r_sum_ed <= w_sum_next;
                end
            end
        end
    end

    assign in_ready   = (r_state == RUN);
    assign busy       = (r_state == RUN) || (r_state == DRAIN);
    assign done       = (r_state == DONE);
    assign sample_cnt = r_sample_cnt;
    assign err_count  = r_err_count;
    assign max_ed     = r_max_ed;
    assign sum_ed     = r_sum_ed;

endmodule

`default_nettype wire

// File: tb/tb_axppa_error_monitor.sv
// +----------------------------------------------------------------------------+
// | tb_axppa_error_monitor : scoreboard bench for the error monitor            |
// | Revision               : 1.0                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_axppa_error_monitor;

    localparam int WIDTH = 16;
    localparam int CNT_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [CNT_W-1:0]  num_samples = '0;
    logic              in_valid = 1'b0;
    logic [WIDTH-1:0]  op_a = '0;
    logic [WIDTH-1:0]  op_b = '0;
    logic [WIDTH:0]    approx_sum = '0;

    logic              in_ready, busy, done;
    logic [CNT_W-1:0]  sample_cnt, err_count;
    logic [WIDTH:0]    max_ed;
    logic [47:0]       sum_ed;

    logic              in_ready8, busy8, done8;
    logic [CNT_W-1:0]  sample_cnt8, err_count8;
    logic [WIDTH:0]    max_ed8;
    logic [7:0]        sum_ed8;

    always #5 clk = ~clk;

    axppa_error_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ACC_W(48)) u_dut (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(in_ready), .op_a(op_a), .op_b(op_b),
        .approx_sum(approx_sum), .busy(busy), .done(done), .sample_cnt(sample_cnt),
        .err_count(err_count), .max_ed(max_ed), .sum_ed(sum_ed)
    );

    axppa_error_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ACC_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(in_ready8), .op_a(op_a), .op_b(op_b),
        .approx_sum(approx_sum), .busy(busy8), .done(done8), .sample_cnt(sample_cnt8),
        .err_count(err_count8), .max_ed(max_ed8), .sum_ed(sum_ed8)
    );

    typedef struct {
        longint unsigned cnt;
        longint unsigned err;
        longint unsigned maxed;
        longint unsigned sum48;
        longint unsigned sum8;
        int              cyc;
    } exp_t;

    exp_t            sb_q[$];
    int              checks = 0;
    int              errors = 0;
    int              cyc = 0;
    logic [15:0]     sa [64];
    logic [15:0]     sb [64];
    logic [16:0]     sx [64];
    longint unsigned m_cnt, m_err, m_max, m_sum;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic longint unsigned ref_ed(input longint unsigned a, input longint unsigned b,
                                               input longint unsigned x);
        longint unsigned s;
        s = a + b;
        return (s > x) ? (s - x) : (x - s);
    endfunction

    function automatic longint unsigned sat(input longint unsigned v, input longint unsigned lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic push_exp(input int done_cyc);
        exp_t e;
        e.cnt   = m_cnt;
        e.err   = m_err;
        e.maxed = m_max;
        e.sum48 = sat(m_sum, 64'h0000_FFFF_FFFF_FFFF);
        e.sum8  = sat(m_sum, 255);
        e.cyc   = done_cyc;
        sb_q.push_back(e);
    endtask

    // Monitor: a rising done is the DUT presenting a finished run.
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_done = 1'b0;
        end else begin
            if (done && !prev_done) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected no pending run");
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("done_cycle", longint'(cyc), longint'(e.cyc));
                    chk("busy_at_done", busy, 0);
                    chk("sample_cnt", sample_cnt, e.cnt);
                    chk("err_count", err_count, e.err);
                    chk("max_ed", max_ed, e.maxed);
                    chk("sum_ed", sum_ed, e.sum48);
                    chk("sum_ed_acc8", sum_ed8, e.sum8);
                    chk("err_count_acc8", err_count8, e.err);
                    chk("done_acc8", done8, 1);
                end
            end
            prev_done = done;
        end
    end

    task automatic wait_done();
        int k = 0;
        while ((sb_q.size() != 0 || !done) && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (sb_q.size() != 0 || !done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got done=%0d pending=%0d expected done=1 pending=0",
                     done, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic do_run(input int n, input int gap, input bit noisy);
        int w;
        @(negedge clk);
        start       = 1'b1;
        num_samples = CNT_W'(n);
        m_cnt = 0; m_err = 0; m_max = 0; m_sum = 0;
        if (n == 0) push_exp(cyc + 1);
        @(negedge clk);
        start = 1'b0;
        if (n > 0) begin
            chk("clear_sample_cnt", sample_cnt, 0);
            chk("clear_err_count", err_count, 0);
            chk("clear_max_ed", max_ed, 0);
            chk("clear_sum_ed", sum_ed, 0);
            chk("clear_busy", busy, 1);
        end
        for (int i = 0; i < n; i++) begin
            repeat (gap) @(negedge clk);
            in_valid   = 1'b1;
            op_a       = sa[i];
            op_b       = sb[i];
            approx_sum = sx[i];
            if (noisy && i > 0) begin
                start       = 1'b1;
                num_samples = CNT_W'($urandom_range(1, 3));
            end
            w = 0;
            while (!in_ready && w < 20) begin
                @(negedge clk);
                w++;
            end
            if (!in_ready) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: got in_ready=0 expected 1");
                in_valid = 1'b0;
                start    = 1'b0;
                return;
            end
            m_cnt++;
            begin
                longint unsigned ed;
                ed = ref_ed(sa[i], sb[i], sx[i]);
                if (ed != 0) m_err++;
                if (ed > m_max) m_max = ed;
                m_sum += ed;
            end
            if (i == n - 1) push_exp(cyc + 1 + 4);
            @(negedge clk);
            in_valid = 1'b0;
            start    = 1'b0;
        end
        if (n > 0) begin
            chk("ready_drop", in_ready, 0);
            chk("busy_drain", busy, 1);
        end
        wait_done();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sample_cnt", sample_cnt, 0);
        chk("rst_sum_ed", sum_ed, 0);
        rst = 1'b0;

        // Reset in the middle of a run with samples still in flight
        @(negedge clk);
        start = 1'b1; num_samples = 5;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; op_a = 16'h0100 + 16'(i); op_b = 16'h0001; approx_sum = '0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("mid_sample_cnt", sample_cnt, 3);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_sample_cnt", sample_cnt, 0);
        chk("midrst_err_count", err_count, 0);
        chk("midrst_max_ed", max_ed, 0);
        chk("midrst_sum_ed", sum_ed, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("flush_err_count", err_count, 0);
        chk("flush_max_ed", max_ed, 0);
        chk("flush_busy", busy, 0);

        // Exact sample
        sa[0] = 16'h0001; sb[0] = 16'h0001; sx[0] = 17'h00002;
        do_run(1, 0, 0);
        // Low-carry approximation, ed = 4
        sa[0] = 16'h0003; sb[0] = 16'h0001; sx[0] = 17'h00000;
        do_run(1, 0, 0);
        // EDs {4,0,16} with gapped valid
        sa[0] = 16'h0003; sb[0] = 16'h0001; sx[0] = 17'h00000;
        sa[1] = 16'h1234; sb[1] = 16'h1111; sx[1] = 17'h02345;
        sa[2] = 16'h0010; sb[2] = 16'h0010; sx[2] = 17'h00010;
        do_run(3, 2, 0);

        // N=0 run from IDLE, then start pulses during a run and with the final accept
        do_reset();
        do_run(0, 0, 0);
        chk("n0_done_hold", done, 1);
        sa[0] = 16'hFFFF; sb[0] = 16'hFFFF; sx[0] = 17'h0FFFE;
        sa[1] = 16'h8000; sb[1] = 16'h8000; sx[1] = 17'h10000;
        sa[2] = 16'h00FF; sb[2] = 16'h0001; sx[2] = 17'h000F0;
        sa[3] = 16'h0000; sb[3] = 16'h0000; sx[3] = 17'h1FFFF;
        do_run(4, 0, 1);

        // Saturation of the narrow accumulator, then a fresh run clears metrics
        for (int i = 0; i < 20; i++) begin
            sa[i] = 16'h0010; sb[i] = 16'h0010; sx[i] = 17'h00030;
        end
        do_run(20, 0, 0);
        sa[0] = 16'h0005; sb[0] = 16'h0005; sx[0] = 17'h0000A;
        sa[1] = 16'h0005; sb[1] = 16'h0005; sx[1] = 17'h0000B;
        do_run(2, 1, 0);

        // Randomized runs
        for (int r = 0; r < 10; r++) begin
            int n;
            n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) begin
                logic [16:0] ex;
                sa[i] = 16'($urandom);
                sb[i] = 16'($urandom);
                ex = {1'b0, sa[i]} + {1'b0, sb[i]};
                case ($urandom_range(0, 2))
                    0:       sx[i] = ex;
                    1:       sx[i] = ex ^ (17'd1 << $urandom_range(0, 8));
                    default: sx[i] = 17'($urandom);
                endcase
            end
            do_run(n, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
